round_sequencer: RTL and testbench
==================================

Name: round_sequencer

Overview:
Round controller for the tug-of-war game. It debounces-free synchronises the two player pushbuttons and runs each round: wait for release, random dark delay, lights on. It arbitrates which player pushed first and produces the leds_on / winrnd / right / tie control set consumed by the scorer. It watches the scorer's 8-bit score word and freezes the game once either side has won.

Parameters:
DELAY_MIN_CYC, 16, minimum dark-phase length in clk cycles (delay = DELAY_MIN_CYC + 8-bit LFSR value)
LIT_TIMEOUT_CYC, 1024, cycles the lights stay on with no push before the round is abandoned
HOLD_CYC, 32, cycles the result is held before the next round starts (must be >= 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
pb_l  in  1  left player button, raw, asynchronous level
pb_r  in  1  right player button, raw, asynchronous level
score  in  8  scorer output word; 8'b11100000 = left wins, 8'b00000111 = right wins
leds_on  out  1  lights indicator to players and scorer
winrnd  out  1  one-cycle pulse: round decided
right  out  1  1 = right player's push decided the round, 0 = left
tie  out  1  both players pushed in the same cycle (valid with winrnd)
game_over  out  1  high once a win pattern is seen on score; held until rst

Behaviour:
- Reset (async, immediate): state WAIT_REL; leds_on, winrnd, right, tie, game_over = 0; counters = 0; LFSR = 8'h01; synchroniser flops = 0.
- Input path per button: s1 <= pb; s2 <= s1; p <= s2; press = s2 & ~p. A level rising before edge k gives press high in the cycle after edge k+1. Press is acted on at edge k+2.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle in every state and is never all-zero.
- All outputs are registered.
- State machine: WAIT_REL, DARK, LIT, HOLD, OVER.
- WAIT_REL: leds_on = 0. When s2_l = 0 and s2_r = 0, go to DARK and load cnt = DELAY_MIN_CYC + lfsr.
- DARK: leds_on = 0; cnt decrements each cycle.
  - Any press: jump-the-light. Go to HOLD; winrnd = 1 for one cycle; leds_on stays 0.
  - Left-only press: right = 0. Right-only press: right = 1. Both in the same cycle: tie = 1, right = 0.
  - cnt reaches 0 with no press: go to LIT, leds_on = 1, cnt = LIT_TIMEOUT_CYC.
  - A press in the same cycle as cnt = 0 counts as a jump.
- LIT: leds_on = 1.
  - First press: go to HOLD; winrnd = 1; right and tie set as in DARK.
  - leds_on remains 1 during the winrnd cycle, then clears on the following edge.
  - cnt reaches 0 with no press: go to WAIT_REL, leds_on = 0, no winrnd.
- Scorer contract: leds_on, right and tie are stable in the same cycle winrnd = 1. winrnd is high for exactly one cycle per decided round.
- Once a round is decided, further presses are ignored until the next DARK.
- HOLD: cnt = HOLD_CYC on entry. right and tie are held, then cleared on exit. At cnt = 0:
  - score == 8'b11100000 or 8'b00000111: go to OVER, game_over = 1.
  - Otherwise: go to WAIT_REL.
  - Score is sampled no earlier than 2 cycles after winrnd, so the scorer has updated.
- OVER: all outputs 0 except game_over = 1. All presses are ignored until rst.
- Held button: a button held from the previous round produces no press edge, and WAIT_REL blocks DARK until both buttons are released.
- Reset mid-round (incl. the winrnd cycle): winrnd drops immediately; no partial round is reported.

Test Plan:
1. Reset, buttons low -> WAIT_REL→DARK in 1 cycle. leds_on rises after DELAY_MIN_CYC..DELAY_MIN_CYC+255 cycles; winrnd never pulses.
2. LIT, pb_r rises -> after 2 edges, winrnd=1 for exactly 1 cycle with leds_on=1, right=1, tie=0. leds_on=0 on the next cycle; a pb_l push 3 cycles later gives no second winrnd.
3. DARK, pb_l rises -> winrnd=1, leds_on=0, right=0, tie=0. No LIT phase that round.
4. LIT, pb_l and pb_r rise in the same cycle -> winrnd=1, tie=1. Next round starts after HOLD_CYC.
5. LIT with no press for LIT_TIMEOUT_CYC -> leds_on=0, no winrnd. Then pb_l held high blocks DARK until released.
6. score forced 8'b00000111 during HOLD -> game_over=1 after HOLD_CYC; subsequent presses give no winrnd. Asserting rst mid-HOLD clears game_over and returns to WAIT_REL.

Source files
------------

// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : round_sequencer
//  Purpose  : Tug-of-war round controller. Synchronises both pushbuttons,
//             runs wait-for-release / random dark delay / lights-on rounds,
//             arbitrates the first push and freezes once the score shows a win.
//  Revision : 1.0  initial release
// ============================================================================
module round_sequencer #(
  parameter int unsigned DELAY_MIN_CYC   = 16,
  parameter int unsigned LIT_TIMEOUT_CYC = 1024,
  parameter int unsigned HOLD_CYC        = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_l,
  input  logic       pb_r,
  input  logic [7:0] score,
  output logic       leds_on,
  output logic       winrnd,
  output logic       right,
  output logic       tie,
  output logic       game_over
);

  // Counter must hold the longest of the three phase lengths.
  localparam int unsigned DARK_MAX = DELAY_MIN_CYC + 255;
  localparam int unsigned MAX_A    = (DARK_MAX > LIT_TIMEOUT_CYC) ? DARK_MAX : LIT_TIMEOUT_CYC;
  localparam int unsigned CNT_MAX  = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [7:0] WIN_LEFT  = 8'b1110_0000;
  localparam logic [7:0] WIN_RIGHT = 8'b0000_0111;

  localparam logic [2:0] ST_WAIT_REL = 3'd0;
  localparam logic [2:0] ST_DARK     = 3'd1;
  localparam logic [2:0] ST_LIT      = 3'd2;
  localparam logic [2:0] ST_HOLD     = 3'd3;
  localparam logic [2:0] ST_OVER     = 3'd4;

  logic             s1_l_q, s2_l_q, p_l_q, s1_l_d, s2_l_d, p_l_d;
  logic             s1_r_q, s2_r_q, p_r_q, s1_r_d, s2_r_d, p_r_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             leds_on_q, leds_on_d;
  logic             winrnd_q, winrnd_d;
  logic             right_q, right_d;
  logic             tie_q, tie_d;
  logic             game_over_q, game_over_d;

  logic             press_l, press_r, any_press, cnt_zero, win_seen;

  // Two-flop synchronisers, a delay flop for edge detection, and the LFSR step.
  always_comb begin
    s1_l_d = pb_l;
    s2_l_d = s1_l_q;
    p_l_d  = s2_l_q;
    s1_r_d = pb_r;
    s2_r_d = s1_r_q;
    p_r_d  = s2_r_q;
    // Fibonacci taps 8,6,5,4: maximal length, so a non-zero seed never hits zero.
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign press_l   = s2_l_q & ~p_l_q;
  assign press_r   = s2_r_q & ~p_r_q;
  assign any_press = press_l | press_r;
  assign cnt_zero  = (cnt_q == '0);
  assign win_seen  = (score == WIN_LEFT) || (score == WIN_RIGHT);

  // Round state machine; every output is computed here and registered below.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    leds_on_d   = leds_on_q;
    winrnd_d    = 1'b0;
    right_d     = right_q;
    tie_d       = tie_q;
    game_over_d = game_over_q;

    case (state_q)
      ST_WAIT_REL: begin
        leds_on_d = 1'b0;
        right_d   = 1'b0;
        tie_d     = 1'b0;
        if (!s2_l_q && !s2_r_q) begin
          state_d = ST_DARK;
          cnt_d   = CNT_W'(DELAY_MIN_CYC) + CNT_W'(lfsr_q);
        end
      end

      ST_DARK, ST_LIT: begin
        // Lights keep their phase value through the winrnd cycle so the
        // scorer sees a stable leds_on alongside the decision.
        leds_on_d = (state_q == ST_LIT);
        if (any_press) begin
          // A press in DARK (even on the last count) is a jump-the-light.
          state_d  = ST_HOLD;
          cnt_d    = CNT_W'(HOLD_CYC);
          winrnd_d = 1'b1;
          right_d  = press_r & ~press_l;
          tie_d    = press_r & press_l;
        end else if (cnt_zero) begin
          if (state_q == ST_DARK) begin
            state_d   = ST_LIT;
            leds_on_d = 1'b1;
            cnt_d     = CNT_W'(LIT_TIMEOUT_CYC);
          end else begin
            state_d   = ST_WAIT_REL;
            leds_on_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_HOLD: begin
        // Score is only examined at the end of HOLD, well after the scorer
        // has absorbed the winrnd pulse.
        leds_on_d = 1'b0;
        if (cnt_zero) begin
          right_d = 1'b0;
          tie_d   = 1'b0;
          if (win_seen) begin
            state_d     = ST_OVER;
            game_over_d = 1'b1;
          end else begin
            state_d = ST_WAIT_REL;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_OVER: begin
        leds_on_d   = 1'b0;
        right_d     = 1'b0;
        tie_d       = 1'b0;
        game_over_d = 1'b1;
      end

      default: begin
        state_d     = ST_WAIT_REL;
        cnt_d       = '0;
        leds_on_d   = 1'b0;
        right_d     = 1'b0;
        tie_d       = 1'b0;
        game_over_d = 1'b0;
      end
    endcase
  end

  // State, counters, synchronisers and output registers with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_l_q      <= 1'b0;
      s2_l_q      <= 1'b0;
      p_l_q       <= 1'b0;
      s1_r_q      <= 1'b0;
      s2_r_q      <= 1'b0;
      p_r_q       <= 1'b0;
      lfsr_q      <= 8'h01;
      state_q     <= ST_WAIT_REL;
      cnt_q       <= '0;
      leds_on_q   <= 1'b0;
      winrnd_q    <= 1'b0;
      right_q     <= 1'b0;
      tie_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      s1_l_q      <= s1_l_d;
      s2_l_q      <= s2_l_d;
      p_l_q       <= p_l_d;
      s1_r_q      <= s1_r_d;
      s2_r_q      <= s2_r_d;
      p_r_q       <= p_r_d;
      lfsr_q      <= lfsr_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      leds_on_q   <= leds_on_d;
      winrnd_q    <= winrnd_d;
      right_q     <= right_d;
      tie_q       <= tie_d;
      game_over_q <= game_over_d;
    end
  end

  assign leds_on   = leds_on_q;
  assign winrnd    = winrnd_q;
  assign right     = right_q;
  assign tie       = tie_q;
  assign game_over = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_round_sequencer
//  Purpose  : Directed rounds for round_sequencer. Expected round decisions
//             are queued when a push is issued and matched on each winrnd.
//  Revision : 1.0  initial release
// ============================================================================
module tb_round_sequencer;

  logic       clk;
  logic       rst;
  logic       pb_l;
  logic       pb_r;
  logic [7:0] score;
  logic       leds_on;
  logic       winrnd;
  logic       right;
  logic       tie;
  logic       game_over;

  round_sequencer #(
    .DELAY_MIN_CYC  (16),
    .LIT_TIMEOUT_CYC(1024),
    .HOLD_CYC       (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pb_l     (pb_l),
    .pb_r     (pb_r),
    .score    (score),
    .leds_on  (leds_on),
    .winrnd   (winrnd),
    .right    (right),
    .tie      (tie),
    .game_over(game_over)
  );

  typedef struct packed {
    logic right;
    logic tie;
    logic leds;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every winrnd pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && winrnd === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_winrnd: got winrnd=1 at %0t, required no decision", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if ({right, tie, leds_on} !== mon_e) begin
          miscompares++;
          $display("FAIL round_result: got right/tie/leds=%b%b%b, required %b%b%b at %0t",
                   right, tie, leds_on, mon_e.right, mon_e.tie, mon_e.leds, $time);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic r, input logic t, input logic l);
    exp_t e;
    e.right = r;
    e.tie   = t;
    e.leds  = l;
    exp_q.push_back(e);
  endtask

  // Bounded wait for lights on; returns at the negedge where leds_on is first seen high.
  task automatic wait_leds(input string name, input int bound);
    int n = 0;
    while (leds_on !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, {15'd0, leds_on}, 16'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic stay_dark;
    rst   = 1'b1;
    pb_l  = 1'b0;
    pb_r  = 1'b0;
    score = 8'h00;
    tick(2);
    check("reset_outputs", {11'd0, leds_on, winrnd, right, tie, game_over}, 16'd0);

    // Round 1: first DARK loads 16 + 1 -> leds rise on the 19th edge after release.
    rst = 1'b0;
    tick(18);
    check("dark_len_lo", {15'd0, leds_on}, 16'd0);
    tick(1);
    check("lit_first", {15'd0, leds_on}, 16'd1);

    // LIT, right push: decided two edges after the synchroniser sees it.
    pb_r = 1'b1;
    push_exp(1'b1, 1'b0, 1'b1);
    tick(3);
    check("winrnd_lat_r", {15'd0, winrnd}, 16'd1);
    tick(1);
    check("lit_clear", {14'd0, leds_on, winrnd}, 16'd0);
    tick(3);
    pb_l = 1'b1;                // ignored: round already decided
    tick(5);
    pb_l = 1'b0;
    pb_r = 1'b0;

    // Round 2: DARK entered 34 edges after winrnd; jump the light while dark.
    tick(27);
    pb_l = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0);
    tick(3);
    check("winrnd_lat_jump", {15'd0, winrnd}, 16'd1);
    tick(1);
    pb_l = 1'b0;
    tick(20);
    check("no_lit_after_jump", {15'd0, leds_on}, 16'd0);

    // Round 3: simultaneous push in LIT is a tie.
    wait_leds("lit_round3", 400);
    pb_l = 1'b1;
    pb_r = 1'b1;
    push_exp(1'b0, 1'b1, 1'b1);
    tick(3);
    check("tie_flag", {14'd0, winrnd, tie}, 16'd3);
    tick(1);
    pb_l = 1'b0;
    pb_r = 1'b0;
    tick(50);
    check("hold_then_dark", {15'd0, leds_on}, 16'd0);

    // Round 4: lights time out after 1025 edges; held button blocks DARK.
    wait_leds("lit_round4", 400);
    tick(1023);
    pb_l = 1'b1;
    tick(1);
    check("lit_timeout_hold", {15'd0, leds_on}, 16'd1);
    tick(1);
    check("lit_timeout_off", {15'd0, leds_on}, 16'd0);
    stay_dark = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (leds_on !== 1'b0) stay_dark = 1'b0;
    end
    check("held_blocks_dark", {15'd0, stay_dark}, 16'd1);
    pb_l = 1'b0;

    // Round 5: right wins the round and the score shows a right-player win.
    wait_leds("lit_round5", 400);
    pb_r = 1'b1;
    push_exp(1'b1, 1'b0, 1'b1);
    tick(3);
    tick(1);
    pb_r  = 1'b0;
    score = 8'b0000_0111;
    tick(31);
    check("game_over_early", {15'd0, game_over}, 16'd0);
    tick(1);
    check("game_over_set", {15'd0, game_over}, 16'd1);
    pb_l = 1'b1;
    tick(5);
    pb_r = 1'b1;
    tick(5);
    pb_l = 1'b0;
    pb_r = 1'b0;
    tick(5);
    check("over_outputs", {11'd0, leds_on, winrnd, right, tie, game_over}, 16'd1);

    // Asynchronous reset out of OVER, then the first round replays exactly.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async_go", {15'd0, game_over}, 16'd0);
    score = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    tick(18);
    check("rst_dark_lo", {15'd0, leds_on}, 16'd0);
    tick(1);
    check("rst_lit", {15'd0, leds_on}, 16'd1);

    // Reset in the middle of HOLD clears the held result.
    pb_r = 1'b1;
    push_exp(1'b1, 1'b0, 1'b1);
    tick(3);
    pb_r = 1'b0;
    tick(10);
    rst = 1'b1;
    #1 check("rst_mid_hold", {11'd0, leds_on, winrnd, right, tie, game_over}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(18);
    check("hold_rst_dark_lo", {15'd0, leds_on}, 16'd0);
    tick(1);
    check("hold_rst_lit", {15'd0, leds_on}, 16'd1);

    // Reset during the winrnd cycle drops the pulse at once.
    pb_l = 1'b1;
    tick(2);
    @(posedge clk);
    #2 check("winrnd_pre_rst", {15'd0, winrnd}, 16'd1);
    rst = 1'b1;
    #1 check("winrnd_rst_drop", {15'd0, winrnd}, 16'd0);
    pb_l = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(40);

    check("scoreboard_drain", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
